// File: rtl/alu_ops_pkg.sv
// Shared opcode encodings and sequencer state type for the ALU operation sequencer.
package alu_ops_pkg;

   localparam logic [3:0] OP_NOP  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_MUL  = 4'b0010;
   localparam logic [3:0] OP_DIV  = 4'b0011;
   localparam logic [3:0] OP_SHL  = 4'b0100;
   localparam logic [3:0] OP_SHR  = 4'b0101;
   localparam logic [3:0] OP_ROL  = 4'b0110;
   localparam logic [3:0] OP_ROR  = 4'b0111;
   localparam logic [3:0] OP_AND  = 4'b1000;
   localparam logic [3:0] OP_OR   = 4'b1001;
   localparam logic [3:0] OP_NEG  = 4'b1010;
   localparam logic [3:0] OP_NOT  = 4'b1011;
   localparam logic [3:0] OP_SHRA = 4'b1100;
   localparam logic [3:0] OP_ADD  = 4'b1101;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StSetup = 3'd1,
      StWait  = 3'd2,
      StDone  = 3'd3,
      StErr   = 3'd4
   } seqState_t;

   // MUL and DIV are the only operations that update HI/LO.
   function automatic logic isHiloOp(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request handshake between the control path (master) and the ALU sequencer (slave).
interface alu_op_sequencer_if #(
   parameter int unsigned WIDTH = 32
);

   logic             req_valid;
   logic             req_ready;
   logic [3:0]       req_op;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;

   modport master (
      output req_valid,
      output req_op,
      output req_a,
      output req_b,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_op,
      input  req_a,
      input  req_b,
      output req_ready
   );

endinterface

// File: rtl/alu_op_check.sv
// Combinational request screening: opcode legality, HI/LO update class and divide-by-zero.
module alu_op_check
   import alu_ops_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] b,
   output logic             legal,
   output logic             writes_hilo,
   output logic             div_zero
);

   always_comb begin
      legal = 1'b0;
      case (op)
         OP_ADD, OP_SUB, OP_MUL, OP_DIV,
         OP_SHL, OP_SHR, OP_ROL, OP_ROR,
         OP_AND, OP_OR, OP_NEG, OP_NOT, OP_SHRA: legal = 1'b1;
         default:                                 legal = 1'b0;
      endcase
   end

   assign writes_hilo = isHiloOp(op);
   assign div_zero    = (op == OP_DIV) && (b == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues one request at a time to the combinational ALU: operands, then opcode for a settle
// window, then captures the results. The opcode returns to NOP between every operation.
module alu_op_sequencer
   import alu_ops_pkg::*;
#(
   parameter int unsigned WIDTH         = 32,
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic              clock,
   input  logic              clear,
   alu_op_sequencer_if.slave req,
   output logic [3:0]        alu_opcode,
   output logic [WIDTH-1:0]  alu_a,
   output logic [WIDTH-1:0]  alu_b,
   input  logic [WIDTH-1:0]  alu_z_low,
   input  logic [WIDTH-1:0]  alu_z_high,
   output logic [WIDTH-1:0]  z_low,
   output logic [WIDTH-1:0]  z_high,
   output logic [WIDTH-1:0]  hi,
   output logic [WIDTH-1:0]  lo,
   output logic              done,
   output logic              err
);

   localparam int unsigned SettleEff = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
   localparam int unsigned CntW      = $clog2(SettleEff + 1);

   seqState_t       stateQ;
   logic [3:0]      opQ;
   logic            hiloQ;
   logic            readyQ;
   logic [CntW-1:0] cntQ;

   logic reqLegal;
   logic reqHilo;
   logic reqDivZero;

   alu_op_check #(
      .WIDTH (WIDTH)
   ) u_check (
      .op          (req.req_op),
      .b           (req.req_b),
      .legal       (reqLegal),
      .writes_hilo (reqHilo),
      .div_zero    (reqDivZero)
   );

   assign req.req_ready = readyQ;

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         stateQ     <= StIdle;
         opQ        <= OP_NOP;
         hiloQ      <= 1'b0;
         readyQ     <= 1'b1;
         cntQ       <= '0;
         alu_opcode <= OP_NOP;
         alu_a      <= '0;
         alu_b      <= '0;
         z_low      <= '0;
         z_high     <= '0;
         hi         <= '0;
         lo         <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         unique case (stateQ)
            StIdle: begin
               readyQ     <= 1'b1;
               alu_opcode <= OP_NOP;
               if (req.req_valid && readyQ) begin
                  readyQ <= 1'b0;
                  if (reqLegal && !reqDivZero) begin
                     opQ    <= req.req_op;
                     hiloQ  <= reqHilo;
                     alu_a  <= req.req_a;
                     alu_b  <= req.req_b;
                     stateQ <= StSetup;
                  end else begin
                     err    <= 1'b1;
                     stateQ <= StErr;
                  end
               end
            end
            StSetup: begin
               // Operands have been stable for a full cycle; now present the real opcode.
               cntQ       <= CntW'(SettleEff);
               alu_opcode <= opQ;
               stateQ     <= StWait;
            end
            StWait: begin
               if (cntQ == CntW'(1)) begin
                  z_low  <= alu_z_low;
                  z_high <= alu_z_high;
                  if (hiloQ) begin
                     lo <= alu_z_low;
                     hi <= alu_z_high;
                  end
                  alu_opcode <= OP_NOP;
                  done       <= 1'b1;
                  stateQ     <= StDone;
               end else begin
                  cntQ <= cntQ - CntW'(1);
               end
            end
            StDone: begin
               readyQ <= 1'b1;
               stateQ <= StIdle;
            end
            StErr: begin
               readyQ <= 1'b1;
               stateQ <= StIdle;
            end
            default: begin
               alu_opcode <= OP_NOP;
               readyQ     <= 1'b1;
               stateQ     <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small behavioural ALU on the result inputs.
module tb_alu_op_sequencer;

   logic        clock;
   logic        clear;
   logic [3:0]  alu_opcode;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_z_low;
   logic [31:0] alu_z_high;
   logic [31:0] z_low;
   logic [31:0] z_high;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        done;
   logic        err;
   logic [63:0] prod;

   int total = 0;
   int bad   = 0;

   alu_op_sequencer_if #(.WIDTH(32)) reqIf ();

   alu_op_sequencer #(
      .WIDTH         (32),
      .SETTLE_CYCLES (1)
   ) dut (
      .clock      (clock),
      .clear      (clear),
      .req        (reqIf),
      .alu_opcode (alu_opcode),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_z_low  (alu_z_low),
      .alu_z_high (alu_z_high),
      .z_low      (z_low),
      .z_high     (z_high),
      .hi         (hi),
      .lo         (lo),
      .done       (done),
      .err        (err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Behavioural ALU, only the operations the directed steps use.
   always_comb begin
      alu_z_low  = '0;
      alu_z_high = '0;
      prod       = '0;
      case (alu_opcode)
         4'b1101: alu_z_low = alu_a + alu_b;
         4'b0010: begin
            prod       = {32'b0, alu_a} * {32'b0, alu_b};
            alu_z_low  = prod[31:0];
            alu_z_high = prod[63:32];
         end
         4'b0011: begin
            if (alu_b != 0) begin
               alu_z_low  = alu_a / alu_b;
               alu_z_high = alu_a % alu_b;
            end
         end
         4'b0100: alu_z_low = alu_a << alu_b[4:0];
         default: ;
      endcase
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Issue a request and advance to the DONE cycle (acceptance + SETUP + one WAIT cycle).
   task automatic runOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      reqIf.req_valid = 1'b1;
      reqIf.req_op    = op;
      reqIf.req_a     = a;
      reqIf.req_b     = b;
      step();
      reqIf.req_valid = 1'b0;
      step();
      step();
   endtask

   initial begin
      clear           = 1'b0;
      reqIf.req_valid = 1'b0;
      reqIf.req_op    = 4'b0000;
      reqIf.req_a     = '0;
      reqIf.req_b     = '0;
      #2;
      chk("rst_opcode", alu_opcode, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_z_low", z_low, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      step();
      step();
      clear = 1'b1;
      step();
      chk("rst_ready", reqIf.req_ready, 1);

      // ADD 5 + 7
      reqIf.req_valid = 1'b1;
      reqIf.req_op    = 4'b1101;
      reqIf.req_a     = 32'd5;
      reqIf.req_b     = 32'd7;
      step();
      chk("add_setup_opcode", alu_opcode, 4'b0000);
      chk("add_setup_ready", reqIf.req_ready, 0);
      chk("add_alu_a", alu_a, 5);
      chk("add_alu_b", alu_b, 7);
      reqIf.req_valid = 1'b0;
      step();
      chk("add_wait_opcode", alu_opcode, 4'b1101);
      chk("add_wait_done", done, 0);
      step();
      chk("add_done", done, 1);
      chk("add_done_opcode", alu_opcode, 4'b0000);
      chk("add_z_low", z_low, 12);
      chk("add_hi", hi, 0);
      chk("add_lo", lo, 0);
      step();
      chk("add_done_drop", done, 0);
      chk("add_ready_back", reqIf.req_ready, 1);

      // MUL 2^16 * 2^16
      runOp(4'b0010, 32'h0001_0000, 32'h0001_0000);
      chk("mul_done", done, 1);
      chk("mul_z_high", z_high, 1);
      chk("mul_z_low", z_low, 0);
      chk("mul_hi", hi, 1);
      chk("mul_lo", lo, 0);
      step();

      // DIV 17 / 5
      runOp(4'b0011, 32'd17, 32'd5);
      chk("div_done", done, 1);
      chk("div_lo", lo, 3);
      chk("div_hi", hi, 2);
      step();

      // DIV 9 / 0 is rejected
      reqIf.req_valid = 1'b1;
      reqIf.req_op    = 4'b0011;
      reqIf.req_a     = 32'd9;
      reqIf.req_b     = 32'd0;
      step();
      chk("div0_err", err, 1);
      chk("div0_no_done", done, 0);
      chk("div0_opcode", alu_opcode, 4'b0000);
      chk("div0_alu_a_kept", alu_a, 17);
      chk("div0_ready", reqIf.req_ready, 0);
      reqIf.req_valid = 1'b0;
      step();
      chk("div0_err_drop", err, 0);
      chk("div0_ready_back", reqIf.req_ready, 1);
      chk("div0_opcode2", alu_opcode, 4'b0000);
      chk("div0_hi", hi, 2);
      chk("div0_lo", lo, 3);

      // Back-to-back SHL with req_valid held
      reqIf.req_valid = 1'b1;
      reqIf.req_op    = 4'b0100;
      reqIf.req_a     = 32'd1;
      reqIf.req_b     = 32'd1;
      step();
      chk("shl1_setup_opcode", alu_opcode, 4'b0000);
      chk("shl1_ready", reqIf.req_ready, 0);
      step();
      chk("shl1_wait_opcode", alu_opcode, 4'b0100);
      step();
      chk("shl1_done", done, 1);
      chk("shl1_z_low", z_low, 2);
      chk("shl1_done_ready", reqIf.req_ready, 0);
      chk("shl1_done_opcode", alu_opcode, 4'b0000);
      step();
      chk("shl_idle_ready", reqIf.req_ready, 1);
      chk("shl_idle_opcode", alu_opcode, 4'b0000);
      chk("shl_idle_done", done, 0);
      reqIf.req_a = 32'd3;
      step();
      chk("shl2_setup_opcode", alu_opcode, 4'b0000);
      chk("shl2_alu_a", alu_a, 3);
      reqIf.req_valid = 1'b0;
      step();
      chk("shl2_wait_opcode", alu_opcode, 4'b0100);
      step();
      chk("shl2_done", done, 1);
      chk("shl2_z_low", z_low, 6);
      chk("shl2_hi_kept", hi, 2);
      chk("shl2_lo_kept", lo, 3);
      step();

      // Reset during WAIT of a MUL
      reqIf.req_valid = 1'b1;
      reqIf.req_op    = 4'b0010;
      reqIf.req_a     = 32'h0002_0000;
      reqIf.req_b     = 32'h0001_0000;
      step();
      reqIf.req_valid = 1'b0;
      step();
      chk("mulrst_wait_opcode", alu_opcode, 4'b0010);
      clear = 1'b0;
      #1;
      chk("mulrst_opcode", alu_opcode, 0);
      chk("mulrst_alu_a", alu_a, 0);
      chk("mulrst_alu_b", alu_b, 0);
      chk("mulrst_z_low", z_low, 0);
      chk("mulrst_z_high", z_high, 0);
      chk("mulrst_hi", hi, 0);
      chk("mulrst_lo", lo, 0);
      chk("mulrst_done", done, 0);
      step();
      chk("mulrst_no_done", done, 0);
      chk("mulrst_hi_held", hi, 0);
      clear = 1'b1;
      step();
      chk("mulrst_ready", reqIf.req_ready, 1);
      runOp(4'b1101, 32'd10, 32'd20);
      chk("postrst_done", done, 1);
      chk("postrst_z_low", z_low, 30);
      chk("postrst_hi", hi, 0);
      step();

      // Illegal opcode 1111
      reqIf.req_valid = 1'b1;
      reqIf.req_op    = 4'b1111;
      reqIf.req_a     = 32'd1;
      reqIf.req_b     = 32'd1;
      step();
      chk("ill_err", err, 1);
      chk("ill_ready", reqIf.req_ready, 0);
      chk("ill_alu_a_kept", alu_a, 10);
      chk("ill_z_low_kept", z_low, 30);
      reqIf.req_valid = 1'b0;
      step();
      chk("ill_err_drop", err, 0);
      chk("ill_ready_back", reqIf.req_ready, 1);
      chk("ill_z_low_kept2", z_low, 30);
      step();
      chk("ill_err_quiet", err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Initiator side of the ALU interface. Accepts one operation request at a time from the control path (opcode plus two 32-bit operands) and presents operands and then opcode to the combinational ALU.
- Waits a fixed settle time, then captures the ALU low/high result outputs into Z registers and, for MUL/DIV, into HI/LO.
- Sits between the control unit and the ALU. Replaces ad-hoc opcode driving, so every issue re-triggers the ALU's opcode-sensitive evaluation.

Parameters:
- WIDTH, 32, operand/result width.
- SETTLE_CYCLES, 1, cycles the real opcode is held on alu_opcode before capture. A value of 0 is treated as 1.

Ports:
- clock  in  1  single clock, rising edge.
- clear  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept.
- req_op  in  4  opcode.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- alu_opcode  out  4  opcode to ALU; 4'b0000 (NOP) when not issuing.
- alu_a  out  WIDTH  operand A to ALU.
- alu_b  out  WIDTH  operand B to ALU.
- alu_z_low  in  WIDTH  ALU low result.
- alu_z_high  in  WIDTH  ALU high result (MUL upper product / DIV remainder).
- z_low  out  WIDTH  captured low result.
- z_high  out  WIDTH  captured high result.
- hi  out  WIDTH  HI register, written only by MUL/DIV.
- lo  out  WIDTH  LO register, written only by MUL/DIV.
- done  out  1  one-cycle pulse; results valid.
- err  out  1  one-cycle pulse; request rejected.

Behaviour:
- Reset (clear=0, async): state=IDLE. alu_a, alu_b, z_low, z_high, hi, lo = 0. alu_opcode=0000. done=0, err=0. req_ready=1 after release.
- Legal opcodes:
  - ADD 1101, SUB 0001, MUL 0010, DIV 0011
  - SHL 0100, SHR 0101, ROL 0110, ROR 0111
  - AND 1000, OR 1001, NEG 1010, NOT 1011, SHRA 1100
  - Illegal: 0000, 1110, 1111.
- States: IDLE, SETUP, WAIT, DONE, ERR.
- IDLE:
  - req_ready=1, alu_opcode=0000.
  - On req_valid&&req_ready with a legal opcode and not (DIV with req_b==0): latch op into op_q, req_a into alu_a, req_b into alu_b; go to SETUP.
  - On an illegal opcode or DIV with req_b==0: go to ERR. alu_a/alu_b are not loaded.
- SETUP: exactly 1 cycle. Operands stable, alu_opcode=0000. Load settle counter with SETTLE_CYCLES; go to WAIT.
- WAIT:
  - alu_opcode=op_q for SETTLE_CYCLES cycles.
  - On the edge ending the last WAIT cycle: z_low<=alu_z_low, z_high<=alu_z_high.
  - If op_q is MUL or DIV, also lo<=alu_z_low and hi<=alu_z_high.
  - Go to DONE.
- DONE: done=1 for 1 cycle, alu_opcode=0000, req_ready=0. Go to IDLE.
- ERR: err=1 for 1 cycle, req_ready=0. All result registers unchanged. Go to IDLE.
- Latency: with acceptance at edge 0, done is high in cycle 2+SETTLE_CYCLES (3 with the default).
- Throughput: one operation per 3+SETTLE_CYCLES cycles.
- NOP separation: alu_opcode always returns to 0000 between operations, so consecutive identical opcodes still produce an opcode transition at the ALU.
- alu_opcode is decoded from the registered state (no combinational path from req_*).
- Request inputs are ignored while req_ready=0. The requester holds req_* until accepted.
- Reset mid-operation (any state): abort immediately with no done/err pulse. Partially captured values are discarded; all registers return to 0.
- z_low/z_high are overwritten by every completed operation. hi/lo keep their value across non-MUL/DIV operations.

Decomposition:
- Shared package alu_ops_pkg: 4-bit opcode localparams listed above, OP_NOP=4'b0000, state encoding constants.
- One combinational sub-module, alu_op_check: input op and b; outputs legal, writes_hilo, div_zero. The rest is the sequencer FSM plus counter in this module.

Test Plan:
- ADD, a=5, b=7, SETTLE_CYCLES=1 -> alu_opcode 0000 during SETUP then 1101 for 1 cycle; done high in cycle 3; z_low=12; hi=lo=0.
- MUL, a=32'h0001_0000, b=32'h0001_0000 -> z_high=1, z_low=0, hi=1, lo=0, done pulse.
- DIV 17/5 -> lo=3, hi=2. Then DIV 9/0 -> err pulse, no done, alu_opcode stays 0000, hi/lo remain 2/3.
- Back-to-back SHL a=1, then SHL a=3 with req_valid held -> alu_opcode sequence 0100, 0000, 0100; z_low=2 then 6; req_ready low from acceptance through DONE.
- Assert clear during WAIT of a MUL -> all outputs 0 immediately, no done; after release req_ready=1 and a new ADD completes normally.
- req_op=4'b1111 -> err for exactly 1 cycle, results unchanged, req_ready high the following cycle.
